// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and the coordinate type
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VIS        = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int H_TOTAL      = H_VIS + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VIS + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_VIS        = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int V_TOTAL      = V_VIS + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VIS + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping position counter plus registered active-low sync
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_enable,
  input  coord_t i_total,
  input  coord_t i_sync_start,
  input  coord_t i_sync_end,
  output coord_t o_count,
  output logic   o_wrap,
  output logic   o_sync_n
);

  coord_t r_count;
  logic   r_sync_n;
  coord_t w_next;

  assign o_wrap = i_enable && (r_count == i_total - 10'd1);

  always_comb begin
    w_next = r_count;
    if (i_enable) w_next = o_wrap ? '0 : r_count + 10'd1;
  end

  // sync is derived from the next count so it lines up with the count it describes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count  <= '0;
      r_sync_n <= 1'b1;
    end else begin
      r_count  <= w_next;
      r_sync_n <= !((w_next >= i_sync_start) && (w_next <= i_sync_end));
    end
  end

  assign o_count  = r_count;
  assign o_sync_n = r_sync_n;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_FRAME_COUNT_EN adds a 16-bit frame counter
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE     = 640,
  parameter int V_VISIBLE     = 480,
  parameter int H_LINE_TOTAL  = H_TOTAL,
  parameter int H_SYNC_FIRST  = H_SYNC_START,
  parameter int H_SYNC_LAST   = H_SYNC_END,
  parameter int V_FRAME_TOTAL = V_TOTAL,
  parameter int V_SYNC_FIRST  = V_SYNC_START,
  parameter int V_SYNC_LAST   = V_SYNC_END
) (
  input  logic   Clk,
  input  logic   Reset,
  output logic   pixel_clk,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output logic   sync,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,output logic [15:0] frame_count
`endif
);

  localparam coord_t C_H_TOTAL = coord_t'(H_LINE_TOTAL);
  localparam coord_t C_H_SS    = coord_t'(H_SYNC_FIRST);
  localparam coord_t C_H_SE    = coord_t'(H_SYNC_LAST);
  localparam coord_t C_V_TOTAL = coord_t'(V_FRAME_TOTAL);
  localparam coord_t C_V_SS    = coord_t'(V_SYNC_FIRST);
  localparam coord_t C_V_SE    = coord_t'(V_SYNC_LAST);
  localparam coord_t C_H_VIS   = coord_t'(H_VISIBLE);
  localparam coord_t C_V_VIS   = coord_t'(V_VISIBLE);

  logic   r_pixel_clk;
  logic   r_blank;
  logic   r_frame_start;
  logic   w_tick;
  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_hs_n;
  logic   w_vs_n;
  coord_t w_x;
  coord_t w_y;
  coord_t w_x_next;
  coord_t w_y_next;

  assign w_tick = r_pixel_clk;

  vga_axis_counter u_h_axis (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_enable     (w_tick),
    .i_total      (C_H_TOTAL),
    .i_sync_start (C_H_SS),
    .i_sync_end   (C_H_SE),
    .o_count      (w_x),
    .o_wrap       (w_h_wrap),
    .o_sync_n     (w_hs_n)
  );

  vga_axis_counter u_v_axis (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_enable     (w_h_wrap),
    .i_total      (C_V_TOTAL),
    .i_sync_start (C_V_SS),
    .i_sync_end   (C_V_SE),
    .o_count      (w_y),
    .o_wrap       (w_v_wrap),
    .o_sync_n     (w_vs_n)
  );

  // Mirror the axis counters' next values so blank is registered in step with DrawX/DrawY
  always_comb begin
    w_x_next = w_x;
    w_y_next = w_y;
    if (w_tick)   w_x_next = w_h_wrap ? '0 : w_x + 10'd1;
    if (w_h_wrap) w_y_next = w_v_wrap ? '0 : w_y + 10'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pixel_clk   <= 1'b0;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel_clk   <= ~r_pixel_clk;
      r_blank       <= (w_x_next < C_H_VIS) && (w_y_next < C_V_VIS);
      r_frame_start <= w_v_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge Clk) begin
    if (Reset)         r_frame_count <= '0;
    else if (w_v_wrap) r_frame_count <= r_frame_count + 16'd1;
  end

  assign frame_count = r_frame_count;
`endif

  assign pixel_clk   = r_pixel_clk;
  assign hs          = w_hs_n;
  assign vs          = w_vs_n;
  assign blank       = r_blank;
  assign sync        = 1'b0;
  assign DrawX       = w_x;
  assign DrawY       = w_y;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench: full-width instance A with random resets, narrow-line instance B for whole frames
module tb_vga_timing_gen;

  logic       Clk;
  logic       rst_a, rst_b;
  logic       pix_a, hs_a, vs_a, blank_a, sync_a, fs_a;
  logic       pix_b, hs_b, vs_b, blank_b, sync_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_a, fc_b;
`endif

  int vectors     = 0;
  int miscompares = 0;
  bit chk         = 0;
  bit b_run       = 0;
  int ea          = 0;
  int eb          = 0;
  int b_frames    = 0;
  int b_wide      = 0;
  int b_blank     = 0;
  int b_vs_low    = 0;
  logic [9:0]  b_first_vs_x = '1;
  logic [9:0]  b_first_vs_y = '1;
  logic [22:0] b_wrap_state = '0;

  vga_timing_gen u_dut_a (
    .Clk         (Clk),
    .Reset       (rst_a),
    .pixel_clk   (pix_a),
    .hs          (hs_a),
    .vs          (vs_a),
    .blank       (blank_a),
    .sync        (sync_a),
    .DrawX       (x_a),
    .DrawY       (y_a),
    .frame_start (fs_a)
`ifdef VGA_FRAME_COUNT_EN
    ,.frame_count (fc_a)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE    (12),
    .H_LINE_TOTAL (20),
    .H_SYNC_FIRST (14),
    .H_SYNC_LAST  (16)
  ) u_dut_b (
    .Clk         (Clk),
    .Reset       (rst_b),
    .pixel_clk   (pix_b),
    .hs          (hs_b),
    .vs          (vs_b),
    .blank       (blank_b),
    .sync        (sync_b),
    .DrawX       (x_b),
    .DrawY       (y_b),
    .frame_start (fs_b)
`ifdef VGA_FRAME_COUNT_EN
    ,.frame_count (fc_b)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs e Clk edges after reset release: ticks = e/2, position = ticks mod frame size
  function automatic logic [25:0] model(input int e, input int ht, input int hv, input int hs0, input int hs1,
                                        input int vt, input int vv, input int vs0, input int vs1);
    int n, p, x, y;
    logic pix, h, v, bl, fs;
    n   = e / 2;
    p   = n % (ht * vt);
    x   = p % ht;
    y   = p / ht;
    pix = (e % 2) == 1;
    h   = !(x >= hs0 && x <= hs1);
    v   = !(y >= vs0 && y <= vs1);
    bl  = (x < hv) && (y < vv);
    fs  = ((e % 2) == 0) && (n > 0) && (p == 0);
    return {pix, h, v, bl, 1'b0, fs, 10'(x), 10'(y)};
  endfunction

  function automatic logic [15:0] frames_of(input int e, input int ht, input int vt);
    return 16'((e / 2) / (ht * vt));
  endfunction

  // Per-cycle compare of both instances against the model
  initial begin
    logic ra, rb;
    forever begin
      @(posedge Clk);
      ra = rst_a;
      rb = rst_b;
      #1;
      ea = ra ? 0 : ea + 1;
      eb = rb ? 0 : eb + 1;
      if (chk) begin
        check("model_a", {38'b0, pix_a, hs_a, vs_a, blank_a, sync_a, fs_a, x_a, y_a},
              {38'b0, model(ea, 800, 640, 656, 751, 525, 480, 490, 491)});
        check("model_b", {38'b0, pix_b, hs_b, vs_b, blank_b, sync_b, fs_b, x_b, y_b},
              {38'b0, model(eb, 20, 12, 14, 16, 525, 480, 490, 491)});
`ifdef VGA_FRAME_COUNT_EN
        check("frame_count_a", {48'b0, fc_a}, {48'b0, frames_of(ea, 800, 525)});
        check("frame_count_b", {48'b0, fc_b}, {48'b0, frames_of(eb, 20, 525)});
`endif
      end
    end
  end

  // Instance B: per-tick statistics over its first frame and frame_start pulse shape
  initial begin
    logic prev_fs;
    prev_fs = 1'b0;
    wait (b_run);
    forever begin
      @(negedge Clk);
      if (b_frames == 0 && !pix_b) begin
        if (blank_b) b_blank++;
        if (!vs_b) begin
          if (b_vs_low == 0) begin
            b_first_vs_x = x_b;
            b_first_vs_y = y_b;
          end
          b_vs_low++;
        end
      end
      if (fs_b) begin
        if (b_frames == 0) b_wrap_state = {x_b, y_b, hs_b, vs_b, blank_b};
        if (prev_fs) b_wide++;
        b_frames++;
      end
      prev_fs = fs_b;
    end
  end

  initial begin
    int hs_low, blank_low, wait_cnt;
    logic [9:0] first_hs_x;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (5) @(negedge Clk);
    check("reset_a", {38'b0, pix_a, hs_a, vs_a, blank_a, sync_a, fs_a, x_a, y_a}, {38'b0, 6'b011100, 20'd0});
    check("reset_b", {38'b0, pix_b, hs_b, vs_b, blank_b, sync_b, fs_b, x_b, y_b}, {38'b0, 6'b011100, 20'd0});
    chk   = 1'b1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    b_run = 1'b1;

    hs_low     = 0;
    blank_low  = 0;
    first_hs_x = '1;
    for (int i = 1; i <= 1600; i++) begin
      @(negedge Clk);
      if (i == 1) check("first_tick_not_yet", {54'b0, x_a}, 64'd0);
      if (i == 2) check("first_tick_edge2", {54'b0, x_a}, 64'd1);
      if (!pix_a) begin
        if (!hs_a) begin
          if (hs_low == 0) first_hs_x = x_a;
          hs_low++;
        end
        if (!blank_a) blank_low++;
      end
    end
    check("line_hs_ticks", 64'(hs_low), 64'd96);
    check("line_hs_first_x", {54'b0, first_hs_x}, 64'd656);
    check("line_blank0_ticks", 64'(blank_low), 64'd160);
    check("line_wrap_xy", {44'b0, x_a, y_a}, {44'b0, 10'd0, 10'd1});

    wait_cnt = 0;
    while (!(x_a == 10'd300 && y_a == 10'd2 && pix_a) && wait_cnt < 5000) begin
      @(negedge Clk);
      wait_cnt++;
    end
    check("midreset_reach_timeout", 64'(wait_cnt < 5000), 64'd1);
    rst_a = 1'b1;
    @(negedge Clk);
    rst_a = 1'b0;
    check("midreset_a", {38'b0, pix_a, hs_a, vs_a, blank_a, sync_a, fs_a, x_a, y_a}, {38'b0, 6'b011100, 20'd0});

    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(1, 2500)) @(negedge Clk);
      rst_a = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge Clk);
      rst_a = 1'b0;
    end

    wait_cnt = 0;
    while (b_frames < 3 && wait_cnt < 80000) begin
      @(negedge Clk);
      wait_cnt++;
    end
    check("b_frames", 64'(b_frames), 64'd3);
    check("b_frame_start_width", 64'(b_wide), 64'd0);
    check("b_frame_blank_ticks", 64'(b_blank), 64'd5760);
    check("b_frame_vs_ticks", 64'(b_vs_low), 64'd40);
    check("b_first_vs_xy", {44'b0, b_first_vs_x, b_first_vs_y}, {44'b0, 10'd0, 10'd490});
    check("b_wrap_state", {41'b0, b_wrap_state}, {41'b0, 10'd0, 10'd0, 3'b111});
`ifdef VGA_FRAME_COUNT_EN
    check("b_frame_count", {48'b0, fc_b}, 64'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
  H_VISIBLE  640  active pixels per line
  V_VISIBLE  480  active lines per frame
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
  Clk        input   1   system clock, 50 MHz; clock is Clk, single domain
  Reset      input   1   reset, synchronous, active-high
  pixel_clk  output  1   Clk/2 pixel strobe, registered
  hs         output  1   horizontal sync, active-low
  vs         output  1   vertical sync, active-low
  blank      output  1   1 = inside visible area (draw), 0 = blanking
  sync       output  1   composite sync, constant 0
  DrawX      output  10  current pixel column, 0..799
  DrawY      output  10  current line, 0..524
  frame_start output 1   one-Clk pulse at frame wrap

Function
REQ-003 pixel_clk SHALL toggle on every Clk edge when not in reset.
REQ-004 Pixel tick SHALL be defined as a Clk edge where pixel_clk is currently 1; only ticks advance counters.
REQ-005 On a tick, DrawX SHALL increment; DrawX == 799 SHALL wrap to 0 and advance DrawY.
REQ-006 DrawY == 524 with DrawX wrap SHALL wrap DrawY to 0.
REQ-007 Timing SHALL use H total 800 (visible 640, front porch 16, sync 96, back porch 48) and V total 525 (visible 480, front porch 10, sync 2, back porch 33).
REQ-008 hs SHALL be 0 exactly for DrawX 656..751; vs SHALL be 0 exactly for DrawY 490..491.
REQ-009 blank SHALL be 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-010 hs, vs and blank SHALL be registers, computed from the next counter value, so they always describe the DrawX/DrawY presented in the same cycle (zero relative latency).
REQ-011 frame_start SHALL be 1 for exactly the one Clk following the tick that wraps (799,524) to (0,0), and 0 otherwise.
REQ-012 Between ticks, all outputs except pixel_clk SHALL hold.
REQ-013 Counter arithmetic SHALL be 10-bit unsigned; no value above 799/524 SHALL ever appear.

Reset
REQ-014 While Reset is high at a Clk edge, the block SHALL load DrawX = 0, DrawY = 0, pixel_clk = 0, hs = 1, vs = 1, blank = 1, frame_start = 0.
REQ-015 Reset asserted mid-frame SHALL override any tick in the same cycle.
REQ-016 After Reset deasserts, the first tick SHALL occur on the second Clk edge.

Configuration
REQ-017 With VGA_FRAME_COUNT_EN defined, the block SHALL add output frame_count[15:0].
REQ-018 frame_count SHALL reset to 0 and increment in the same cycle as frame_start, wrapping 0xFFFF to 0.
REQ-019 Without VGA_FRAME_COUNT_EN, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-020 Package vga_timing_pkg SHALL hold the H/V totals, porch and sync constants, and the 10-bit coordinate typedef.
REQ-021 A single sub-module, vga_axis_counter, SHALL be instantiated twice: once for H and once for V.
REQ-022 vga_axis_counter SHALL take enable, total, sync_start and sync_end, and return count, wrap and sync_n.

Verification
REQ-023 Scenario, reset: Reset held 5 Clk -> DrawX = 0, DrawY = 0, hs = vs = 1, blank = 1, pixel_clk = 0, frame_start = 0.
REQ-024 Scenario, one line: 1600 Clk after reset -> DrawX steps every 2 Clk.
  - hs low for exactly 96 ticks, starting at DrawX = 656.
  - blank = 0 for DrawX 640..799.
  - DrawY goes 0 -> 1 at the wrap.
REQ-025 Scenario, full frame: 840000 Clk -> frame_start pulses exactly once, one Clk wide.
  - vs low only for DrawY 490..491.
  - 640 x 480 = 307200 ticks with blank = 1.
REQ-026 Scenario, mid-frame reset: Reset pulsed 1 Clk at DrawX = 300, DrawY = 100 -> next cycle shows all REQ-014 values.
  - Counting restarts from (0,0).
  - No frame_start is emitted.
REQ-027 Scenario, boundary: at tick (799,524) -> next values are (0,0), hs = 1, vs = 1, blank = 1, frame_start = 1.
REQ-028 Scenario, macro build: VGA_FRAME_COUNT_EN defined, 3 frames run -> frame_count = 3.
  - frame_count preset to 0xFFFF then one frame -> frame_count = 0.
